// File: rtl/bus_arbiter_8.sv
// Round-robin arbiter for the shared 16-bit internal bus: one owner at a time,
// registered one-hot grant and mux select, one dead cycle between owners.
module bus_arbiter_8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       bus_valid,
  output logic [1:0] dbg_state
);

  // Handshake: req[i] is held high by a unit for as long as it wants the bus;
  // gnt[i] (registered, one-hot) tells unit i it owns the bus this cycle, and
  // the owner dropping req[i] is the release. bus_valid == |gnt.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] MAX_HOLD_L = 8'(MAX_HOLD);

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;

  logic       found;
  logic [2:0] winner;
  logic [2:0] idx;
  logic [7:0] others;
  logic       preempt;

  // Scan from the farthest offset down so the nearest set bit to ptr wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // During GRANT sel always holds the current owner's index.
  always_comb begin
    others  = req & ~(8'd1 << sel);
    preempt = (MAX_HOLD != 0) && (hold_cnt >= MAX_HOLD_L) && (others != 8'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= 8'd0;
      gnt       <= 8'd0;
      sel       <= 3'd0;
      bus_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (found) begin
            state     <= GRANT;
            gnt       <= 8'd1 << winner;
            sel       <= winner;
            ptr       <= winner + 3'd1;
            hold_cnt  <= 8'd1;
            bus_valid <= 1'b1;
          end else begin
            state     <= IDLE;
            gnt       <= 8'd0;
            bus_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (!req[sel] || preempt) begin
            state     <= GAP;
            gnt       <= 8'd0;
            bus_valid <= 1'b0;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= 8'd0;
          bus_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Bench for bus_arbiter_8: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against an owner/pointer model.
module tb_bus_arbiter_8;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       bus_valid;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  bus_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .bus_valid (bus_valid),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // owner = -1 means nobody holds the bus; in_gap marks the forced dead cycle.
  int m_owner  = -1;
  bit m_in_gap = 1'b0;
  int m_ptr    = 0;
  int m_hold   = 0;
  int m_sel    = 0;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (reset) begin
      m_owner = -1; m_in_gap = 1'b0; m_ptr = 0; m_hold = 0; m_sel = 0;
    end else if (m_owner >= 0) begin
      logic [7:0] rest;
      rest = req;
      rest[m_owner] = 1'b0;
      if (!req[m_owner] || (MAX_HOLD != 0 && m_hold >= MAX_HOLD && rest != 8'd0)) begin
        m_owner  = -1;
        m_in_gap = 1'b1;
      end else begin
        m_hold = (m_hold < 255) ? m_hold + 1 : 255;
      end
    end else begin
      w = pick(req, m_ptr);
      m_in_gap = 1'b0;
      if (w >= 0) begin
        m_owner = w;
        m_sel   = w;
        m_ptr   = (w + 1) % 8;
        m_hold  = 1;
      end
    end
  end

  function automatic logic [7:0] exp_gnt();
    return (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("model_gnt", 32'(gnt), 32'(exp_gnt()));
    chk("model_sel", 32'(sel), 32'(m_sel));
    chk("model_bus_valid", 32'(bus_valid), 32'(m_owner >= 0));
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = 8'h00;
    tick(2);
    reset = 1'b0;
  endtask

  logic [7:0] pre_pat [14];

  initial begin
    reset = 1'b1;
    req   = 8'hFF;

    // Reset held with all requests: nothing granted.
    tick(3);
    chk("rst_gnt", 32'(gnt), 32'h00);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_bv", 32'(bus_valid), 32'd0);
    reset = 1'b0;
    tick(1);
    chk("rst_first_gnt", 32'(gnt), 32'h01);
    chk("rst_first_sel", 32'(sel), 32'd0);

    // Release handover: 02,02,00,04 with sel 1,1,1,2.
    apply_reset();
    req = 8'h06;
    tick(1); chk("ho_gnt0", 32'(gnt), 32'h02); chk("ho_sel0", 32'(sel), 32'd1);
    tick(1); chk("ho_gnt1", 32'(gnt), 32'h02); chk("ho_sel1", 32'(sel), 32'd1);
    req = 8'h04;
    tick(1); chk("ho_gnt2", 32'(gnt), 32'h00); chk("ho_sel2", 32'(sel), 32'd1);
    tick(1); chk("ho_gnt3", 32'(gnt), 32'h04); chk("ho_sel3", 32'(sel), 32'd2);

    // Preemption with two constant requesters.
    apply_reset();
    pre_pat = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
                8'h04, 8'h04, 8'h04, 8'h04, 8'h00,
                8'h01, 8'h01, 8'h01, 8'h01};
    req = 8'h05;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      chk($sformatf("pre_gnt%0d", i), 32'(gnt), 32'(pre_pat[i]));
    end

    // Wrap-around after unit 7.
    apply_reset();
    req = 8'h80;
    tick(1); chk("wrap_gnt7", 32'(gnt), 32'h80);
    req = 8'h00;
    tick(2); chk("wrap_idle", 32'(gnt), 32'h00);
    req = 8'h81;
    tick(1); chk("wrap_gnt0", 32'(gnt), 32'h01);
    chk("wrap_ptr", 32'(m_ptr), 32'd1);

    // Sole requester is never preempted.
    apply_reset();
    req = 8'h08;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      chk("sole_gnt", 32'(gnt), 32'h08);
      chk("sole_sel", 32'(sel), 32'd3);
    end

    // Reset mid-grant.
    apply_reset();
    req = 8'h20;
    tick(1); chk("mid_own5", 32'(gnt), 32'h20);
    req = 8'h21;
    tick(1); chk("mid_ignore", 32'(gnt), 32'h20);
    reset = 1'b1;
    tick(1); chk("mid_rst", 32'(gnt), 32'h00);
    reset = 1'b0;
    tick(1); chk("mid_after", 32'(gnt), 32'h01);

    // Randomized traffic: sparse bit toggles, occasional reset pulses.
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      req   = req ^ 8'($urandom & $urandom & $urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    reset = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
